glitch_sweep_ctrl: RTL



---
 rtl/glitch_sweep_ctrl_pkg.sv | 29 ++
 rtl/glitch_sweep_ctrl_if.sv | 49 ++++
 rtl/glitch_sweep_ctrl_cycle_timer.sv | 42 ++++
 rtl/glitch_sweep_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/glitch_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : desynk_pkg
//  Description : Shared definitions for the glitch sweep controller: default
//                datapath widths and the sweep state encoding.
//                The status register block decodes the same encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package desynk_pkg;

    localparam int DEFAULT_DELAY_W = 32;
    localparam int DEFAULT_REP_W   = 8;
    localparam int DEFAULT_TMO_W   = 24;
    localparam int DEFAULT_MISS_W  = 16;

    localparam int SWEEP_STATE_W   = 3;

    typedef enum logic [SWEEP_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_WAIT = 3'd3,
        ST_HOLD = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6
    } sweep_state_t;

endpackage : desynk_pkg
`default_nettype wire

// File: rtl/glitch_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : glitch_sweep_ctrl_if
//  Description : Host/delay-stage bundle for the glitch sweep controller.
//                master : host side (drives start/abort/cfg_*, fired level)
//                slave  : controller side (drives delay_out, set_delay, arm,
//                         busy, done, miss_count, cur_repeat)
//  Revision    : 1.0 - initial release
// ============================================================================
interface glitch_sweep_ctrl_if
    import desynk_pkg::*;
#(
    parameter int DELAY_W = DEFAULT_DELAY_W,
    parameter int REP_W   = DEFAULT_REP_W,
    parameter int TMO_W   = DEFAULT_TMO_W,
    parameter int MISS_W  = DEFAULT_MISS_W
);
    logic               start;
    logic               abort;
    logic [DELAY_W-1:0] cfg_start;
    logic [DELAY_W-1:0] cfg_end;
    logic [DELAY_W-1:0] cfg_step;
    logic [REP_W-1:0]   cfg_repeats;
    logic [TMO_W-1:0]   cfg_timeout;
    logic [TMO_W-1:0]   cfg_holdoff;
    logic               fired;

    logic [DELAY_W-1:0] delay_out;
    logic               set_delay;
    logic               arm;
    logic               busy;
    logic               done;
    logic [MISS_W-1:0]  miss_count;
    logic [REP_W-1:0]   cur_repeat;

    modport master (
        output start, abort, cfg_start, cfg_end, cfg_step, cfg_repeats,
               cfg_timeout, cfg_holdoff, fired,
        input  delay_out, set_delay, arm, busy, done, miss_count, cur_repeat
    );

    modport slave (
        input  start, abort, cfg_start, cfg_end, cfg_step, cfg_repeats,
               cfg_timeout, cfg_holdoff, fired,
        output delay_out, set_delay, arm, busy, done, miss_count, cur_repeat
    );

endinterface : glitch_sweep_ctrl_if
`default_nettype wire

// File: rtl/glitch_sweep_ctrl_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_timer
//  Description : Loadable down-counter. load_i has priority over counting,
//                clear_i forces zero. expire_o is high once the count is at
//                or below one, i.e. on the edge that completes a loaded span
//                of N cycles (a load of 0 or 1 expires on the first edge).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                clear_i         - force count to zero
//                load_i          - load load_val_i
//                en_i            - count down by one (stops at zero)
//                expire_o        - count <= 1
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int WIDTH = 24
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              clear_i,
    input  wire              load_i,
    input  wire  [WIDTH-1:0] load_val_i,
    input  wire              en_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign expire_o = (cnt_q <= WIDTH'(1));

endmodule : cycle_timer
`default_nettype wire

// File: rtl/glitch_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : glitch_sweep_ctrl
//  Description : Fault-injection sweep sequencer. Programs a delay, arms the
//                trigger path, waits for the delayed trigger (or a timeout),
//                holds off while the target recovers, repeats each point and
//                steps the delay up to the inclusive end value.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - glitch_sweep_ctrl_if.slave (start/abort/cfg_*,
//                           fired in; delay_out, set_delay, arm, busy, done,
//                           miss_count, cur_repeat out; all outputs registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module glitch_sweep_ctrl
    import desynk_pkg::*;
#(
    parameter int DELAY_W = DEFAULT_DELAY_W,
    parameter int REP_W   = DEFAULT_REP_W,
    parameter int TMO_W   = DEFAULT_TMO_W,
    parameter int MISS_W  = DEFAULT_MISS_W
) (
    input  wire                clk,
    input  wire                rst,
    glitch_sweep_ctrl_if.slave bus
);

    sweep_state_t        state_q;
    logic [DELAY_W-1:0]  cur_q;
    logic [DELAY_W-1:0]  end_q;
    logic [DELAY_W-1:0]  step_q;
    logic [REP_W-1:0]    reps_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    hold_q;
    logic [REP_W-1:0]    rep_q;
    logic [MISS_W-1:0]   miss_q;
    logic                set_delay_q;
    logic                arm_q;
    logic                busy_q;
    logic                done_q;
    logic                fired_q;

    logic [DELAY_W:0]    w_sum;
    logic                w_last;
    logic                w_rep_more;
    logic                w_hit;
    logic                w_wait_expire;
    logic                w_hold_expire;
    logic                w_timeout;

    // One extra bit so a wrapping increment compares above any end value.
    assign w_sum      = {1'b0, cur_q} + {1'b0, step_q};
    assign w_last     = (step_q == '0) || (w_sum > {1'b0, end_q});
    assign w_rep_more = ({1'b0, rep_q} + (REP_W + 1)'(1)) < {1'b0, reps_q};

    // Only a 0->1 transition counts; a level already high on entry does not.
    assign w_hit      = bus.fired && !fired_q;
    assign w_timeout  = w_wait_expire && (tmo_q != '0);

    // Timeout timer: loaded in ARM so it counts exactly cfg_timeout WAIT cycles.
    cycle_timer #(.WIDTH(TMO_W)) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (bus.abort),
        .load_i     (state_q == ST_ARM),
        .load_val_i (tmo_q),
        .en_i       (state_q == ST_WAIT),
        .expire_o   (w_wait_expire)
    );

    // Hold-off timer: reloaded every WAIT cycle so the value on the exit edge
    // is fresh when HOLD starts counting.
    cycle_timer #(.WIDTH(TMO_W)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (bus.abort),
        .load_i     (state_q == ST_WAIT),
        .load_val_i (hold_q),
        .en_i       (state_q == ST_HOLD),
        .expire_o   (w_hold_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            end_q       <= '0;
            step_q      <= '0;
            reps_q      <= '0;
            tmo_q       <= '0;
            hold_q      <= '0;
            rep_q       <= '0;
            miss_q      <= '0;
            set_delay_q <= 1'b0;
            arm_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fired_q     <= 1'b0;
        end else begin
            fired_q     <= bus.fired;
            set_delay_q <= 1'b0;
            done_q      <= 1'b0;

            if (bus.abort) begin
                state_q <= ST_IDLE;
                arm_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            cur_q       <= bus.cfg_start;
                            end_q       <= bus.cfg_end;
                            step_q      <= bus.cfg_step;
                            reps_q      <= (bus.cfg_repeats == '0) ? REP_W'(1)
                                                                  : bus.cfg_repeats;
                            tmo_q       <= bus.cfg_timeout;
                            hold_q      <= bus.cfg_holdoff;
                            rep_q       <= '0;
                            miss_q      <= '0;
                            set_delay_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        state_q <= ST_ARM;
                    end
                    ST_ARM: begin
                        arm_q   <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (w_hit) begin
                            state_q <= ST_HOLD;
                        end else if (w_timeout) begin
                            if (miss_q != '1) begin
                                miss_q <= miss_q + MISS_W'(1);
                            end
                            state_q <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        arm_q <= 1'b0;
                        if (w_hold_expire && !bus.fired) begin
                            state_q <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (w_rep_more) begin
                            rep_q   <= rep_q + REP_W'(1);
                            state_q <= ST_ARM;
                        end else begin
                            rep_q <= '0;
                            if (w_last) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                cur_q       <= w_sum[DELAY_W-1:0];
                                set_delay_q <= 1'b1;
                                state_q     <= ST_LOAD;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        arm_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.delay_out  = cur_q;
    assign bus.set_delay  = set_delay_q;
    assign bus.arm        = arm_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.miss_count = miss_q;
    assign bus.cur_repeat = rep_q;

endmodule : glitch_sweep_ctrl
`default_nettype wire
